// File: rtl/uart_msg_streamer.sv
// uart_msg_streamer
//   Streams a byte string from a synchronous ROM (one-cycle read latency) onto
//   a UART line. It runs periodically (mode=0) or once per trigger pulse
//   (mode=1). Parity and stop-bit count are set by parameters.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   mode      0 = periodic repeat, 1 = one message per trigger
//   trigger   single-cycle start request (mode 1 only)
//   msg_base  ROM address of the first byte, latched at message start
//   msg_len   byte count, latched at message start
//   rom_addr  registered ROM address
//   rom_data  ROM read data, valid one cycle after rom_addr
//   busy      high from message start until done
//   done      one-cycle pulse after the last stop bit
//   uart_tx   serial output, idle high
module uart_msg_streamer #(
    parameter int CLK_FRE   = 27,
    parameter int BAUD_RATE = 115200,
    parameter int ADDR_W    = 8,
    parameter int PERIOD_MS = 1000,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              trigger,
    input  logic [ADDR_W-1:0] msg_base,
    input  logic [ADDR_W-1:0] msg_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              busy,
    output logic              done,
    output logic              uart_tx
);

    // DIV must be at least 2 so the next frame can be loaded one cycle early.
    localparam int unsigned DIV        = (CLK_FRE * 1_000_000) / BAUD_RATE;
    localparam int unsigned FRAME_BITS = 9 + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int unsigned PERIOD_CYC = PERIOD_MS * CLK_FRE * 1000;
    localparam int          DIV_W      = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int          WAIT_W     = $clog2(PERIOD_CYC);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_PRE   = DIV_W'(DIV - 2);
    localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);
    // IDLE, FETCH and LOAD each take one cycle before the start bit appears,
    // so WAIT is shortened by those cycles (plus the exit compare) to make the
    // line idle exactly PERIOD_CYC cycles between done and the next start bit.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PERIOD_CYC - 4);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        WAIT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] len_q;
    logic [7:0]        data_q;
    logic [3:0]        bit_cnt;
    logic [DIV_W-1:0]  baud_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W:0]   next_idx;
    logic              more;

    assign next_idx = {1'b0, idx} + (ADDR_W + 1)'(1);
    assign more     = next_idx < {1'b0, len_q};

    // Line level for frame position pos: start, 8 data LSB first,
    // optional parity, then stop bits.
    function automatic logic frame_bit(input logic [3:0] pos, input logic [7:0] data);
        logic b;
        if (pos == 4'd0) begin
            b = 1'b0;
        end else if (pos <= 4'd8) begin
            b = data[pos[2:0] - 3'd1];
        end else if ((PARITY != 0) && (pos == 4'd9)) begin
            b = (PARITY == 2) ? ~(^data) : ^data;
        end else begin
            b = 1'b1;
        end
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            len_q    <= '0;
            data_q   <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            wait_cnt <= '0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mode || trigger) begin
                        rom_addr <= msg_base;
                        len_q    <= msg_len;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (len_q == '0) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        wait_cnt <= '0;
                        state    <= mode ? IDLE : WAIT;
                    end else begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    data_q   <= rom_data;
                    rom_addr <= rom_addr + ADDR_W'(1);
                    uart_tx  <= 1'b0;
                    bit_cnt  <= '0;
                    baud_cnt <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt == BIT_LAST && baud_cnt == DIV_LAST) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        wait_cnt <= '0;
                        state    <= mode ? IDLE : WAIT;
                    end else if (bit_cnt == BIT_LAST && baud_cnt == DIV_PRE && more) begin
                        // LOAD occupies the last cycle of this stop bit, so the
                        // next start bit follows with no idle gap.
                        idx   <= next_idx[ADDR_W-1:0];
                        state <= LOAD;
                    end else if (baud_cnt == DIV_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 4'd1;
                        uart_tx  <= frame_bit(bit_cnt + 4'd1, data_q);
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
                WAIT: begin
                    if (mode || wait_cnt == WAIT_LAST) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
